// File: rtl/alu_muldiv.sv
// alu_muldiv: multi-cycle MULT/DIV unit with architectural HI/LO.
// Shift-add multiply and restoring divide, one bit per cycle.
module alu_muldiv #(
  parameter int NB_DATA = 32,
  parameter int NB_OP   = 6,
  parameter int NB_CNT  = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_OP-1:0]   i_op,
  input  logic [NB_DATA-1:0] i_datoA,
  input  logic [NB_DATA-1:0] i_datoB,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_stall,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo,
  output logic [NB_DATA-1:0] o_result
);

  localparam int N = NB_DATA;

  localparam logic [NB_OP-1:0] F_MFHI  = NB_OP'(6'b010000);
  localparam logic [NB_OP-1:0] F_MTHI  = NB_OP'(6'b010001);
  localparam logic [NB_OP-1:0] F_MFLO  = NB_OP'(6'b010010);
  localparam logic [NB_OP-1:0] F_MTLO  = NB_OP'(6'b010011);
  localparam logic [NB_OP-1:0] F_MULT  = NB_OP'(6'b011000);
  localparam logic [NB_OP-1:0] F_MULTU = NB_OP'(6'b011001);
  localparam logic [NB_OP-1:0] F_DIV   = NB_OP'(6'b011010);
  localparam logic [NB_OP-1:0] F_DIVU  = NB_OP'(6'b011011);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [NB_CNT-1:0] LAST = NB_CNT'(N - 1);

  logic [1:0]        state;
  logic [NB_CNT-1:0] cnt;
  logic [N-1:0]      hi, lo, b_mag;
  logic [2*N-1:0]    acc, acc_nxt;
  logic              is_div, neg_q, neg_r, done;

  logic          op_mul, op_div, op_sgn, op_ok, busy;
  logic          a_neg, b_neg;
  logic [N-1:0]  a_abs, b_abs;
  logic [N:0]    mul_sum, div_sh, div_diff;
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]  q_raw, r_raw, q_fix, r_fix;
  logic [N-1:0]  fix_hi, fix_lo;

  always_comb begin
    op_mul = (i_op == F_MULT) || (i_op == F_MULTU);
    op_div = (i_op == F_DIV) || (i_op == F_DIVU);
    op_sgn = (i_op == F_MULT) || (i_op == F_DIV);
    op_ok  = op_mul || op_div ||
             (i_op == F_MFHI) || (i_op == F_MTHI) ||
             (i_op == F_MFLO) || (i_op == F_MTLO);
    busy   = (state != S_IDLE);
    a_neg  = op_sgn && i_datoA[N-1];
    b_neg  = op_sgn && i_datoB[N-1];
    a_abs  = a_neg ? -i_datoA : i_datoA;
    b_abs  = b_neg ? -i_datoB : i_datoB;
  end

  // Divide keeps {remainder, dividend/quotient} in acc; multiply
  // keeps {partial product, remaining multiplier bits}.
  always_comb begin
    mul_sum  = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, b_mag} : '0);
    div_sh   = {acc[2*N-1:N], acc[N-1]};
    div_diff = div_sh - {1'b0, b_mag};
    if (!is_div)
      acc_nxt = {mul_sum, acc[N-1:1]};
    else if (div_diff[N])
      acc_nxt = {div_sh[N-1:0], acc[N-2:0], 1'b0};
    else
      acc_nxt = {div_diff[N-1:0], acc[N-2:0], 1'b1};
  end

  // Zero divisor: remainder path already reproduces A after sign fix.
  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    q_raw    = acc[N-1:0];
    r_raw    = acc[2*N-1:N];
    q_fix    = neg_q ? -q_raw : q_raw;
    r_fix    = neg_r ? -r_raw : r_raw;
    if (is_div) begin
      fix_hi = r_fix;
      fix_lo = (b_mag == '0) ? '1 : q_fix;
    end else begin
      fix_hi = prod_fix[2*N-1:N];
      fix_lo = prod_fix[N-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      b_mag  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_start && (op_mul || op_div)) begin
            acc    <= {{N{1'b0}}, a_abs};
            b_mag  <= b_abs;
            is_div <= op_div;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            cnt    <= '0;
            state  <= S_RUN;
          end else if (i_start && (i_op == F_MTHI)) begin
            hi <= i_datoA;
          end else if (i_start && (i_op == F_MTLO)) begin
            lo <= i_datoA;
          end
        end
        S_RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + NB_CNT'(1);
          if (cnt == LAST) state <= S_FIX;
        end
        S_FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_busy   = busy;
  assign o_done   = done;
  assign o_stall  = busy && i_start && op_ok;
  assign o_hi     = hi;
  assign o_lo     = lo;
  assign o_result = (i_op == F_MFHI) ? hi :
                    (i_op == F_MFLO) ? lo : '0;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: scoreboard bench for the multi-cycle MULT/DIV unit.
// Expected {HI,LO} queued at issue, popped on o_done.
module tb_alu_muldiv;

  localparam int N = 32;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic          clk, rst, start;
  logic [5:0]    op;
  logic [N-1:0]  a, b;
  logic          busy, done, stall;
  logic [N-1:0]  hi, lo, result;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  alu_muldiv #(.NB_DATA(N), .NB_OP(6), .NB_CNT(6)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_start (start),
    .i_op    (op),
    .i_datoA (a),
    .i_datoB (b),
    .o_busy  (busy),
    .o_done  (done),
    .o_stall (stall),
    .o_hi    (hi),
    .o_lo    (lo),
    .o_result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [5:0] f,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
    logic signed [63:0] sx, sy, q, r;
    logic [63:0] res;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    res = '0;
    case (f)
      F_MULT:  res = sx * sy;
      F_MULTU: res = {32'b0, x} * {32'b0, y};
      F_DIV: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      F_DIVU: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else res = {x % y, x / y};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
      else chk("hilo", {hi, lo}, exp_q.pop_front());
    end
  end

  task automatic do_op(input logic [5:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic [63:0] e);
    int bc;
    bit seen;
    @(negedge clk);
    op = f; a = x; b = y; start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0; op = '0;
    bc = 0;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) bc++;
      @(negedge clk);
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("busy_cycles", 64'(bc), 64'(N + 1));
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    logic [5:0]  rf;
    logic [31:0] ra, rb;
    bit seen;

    rst = 1'b1; start = 1'b0; op = F_MFHI; a = '0; b = '0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(F_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    op = F_MFLO;
    #1 chk("mflo", 64'(result), 64'hFFFF_FFF1);
    op = F_MFHI;
    #1 chk("mfhi", 64'(result), 64'hFFFF_FFFF);

    do_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    do_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(F_DIVU, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF);
    do_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    do_op(F_DIV, 32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9_FFFF_FFFF);

    for (int k = 0; k < 6; k++) begin
      rf = 6'b011000 | 6'($urandom_range(0, 3));
      ra = $urandom;
      rb = (k == 5) ? 32'd0 : $urandom;
      if (k == 2) rb = rb >> 20;
      do_op(rf, ra, rb, model(rf, ra, rb));
    end

    @(negedge clk);
    op = F_MTLO; a = 32'hCAFE_0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo", 64'(lo), 64'hCAFE_0001);
    chk("mtlo_nodone", 64'(done), 64'd0);

    // MULT 2*3, then MTHI held by a stalled pipeline until done
    @(negedge clk);
    op = F_MULT; a = 32'd2; b = 32'd3; start = 1'b1;
    exp_q.push_back(64'd6);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    op = 6'b100000; start = 1'b1;
    #1 chk("stall_unsup", 64'(stall), 64'd0);
    op = F_MFLO;
    #1 chk("stall_mflo", 64'(stall), 64'd1);
    chk("stale_lo", 64'(result), 64'hCAFE_0001);
    op = F_MTHI; a = 32'h0000_1234;
    #1 chk("stall_mthi", 64'(stall), 64'd1);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (hi == 32'h0000_1234) begin
        chk("hi_held", 64'(hi), 64'd0);
        break;
      end
    end
    chk("mthi_done_seen", 64'(seen), 64'd1);
    chk("mthi_nostall", 64'(stall), 64'd0);
    @(negedge clk);
    start = 1'b0;
    chk("mthi_retry", {hi, lo}, 64'h0000_1234_0000_0006);

    // reset during RUN aborts the op
    @(negedge clk);
    op = F_MULT; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_idle", 64'(busy), 64'd0);
    chk("abort_hilo2", {hi, lo}, 64'd0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
